input_debounce: RTL and testbench
=================================

// Module: input_debounce
// PURPOSE
//  Input conditioning stage that feeds the DFF/register stages with a clean level.
//  Synchronises an asynchronous pin (d_async) into the clk domain, then debounces it.
//  Emits a debounced level plus single-cycle rise/fall pulses for downstream logic.
// PARAMETERS
//  SYNC_STAGES    2  synchroniser flop count; must be >=2 (elaboration $error otherwise)
//  STABLE_CYCLES  4  consecutive mismatching samples needed to accept a new level; must be >=2
//  RESET_LEVEL    0  value loaded into the sync chain and into q during reset
// PORTS
//  clk      in   1  rising-edge clock
//  rst      in   1  synchronous, active-high reset
//  d_async  in   1  raw asynchronous input (button/pin)
//  q        out  1  debounced level
//  rise     out  1  one-cycle pulse when q goes 0->1
//  fall     out  1  one-cycle pulse when q goes 1->0 (only with macro, see CONFIGURATION)
//  busy     out  1  high while a candidate transition is being qualified (FSM in CHECK)
// BEHAVIOUR
//  Interface: one clock (clk); rst is synchronous and active-high.
//  Reset (rst=1 at an edge): all sync flops=RESET_LEVEL, q=RESET_LEVEL, rise=fall=0,
//   state=STABLE, cnt=0. Any pending qualification is discarded and no pulse is emitted.
//  Sync chain: s[0]<=d_async, s[i]<=s[i-1]; d_sync=s[SYNC_STAGES-1]. No logic between stages.
//  Counter cnt: width $clog2(STABLE_CYCLES+1); it never reaches STABLE_CYCLES (no wrap).
//  FSM states are STABLE and CHECK; mismatch = (d_sync != q).
//   STABLE: on mismatch -> CHECK, cnt<=1. No mismatch -> stay.
//   CHECK, no mismatch -> STABLE, cnt<=0; glitch is rejected, q unchanged, no pulse.
//   CHECK, mismatch, cnt<STABLE_CYCLES-1 -> cnt<=cnt+1.
//   CHECK, mismatch, cnt==STABLE_CYCLES-1 -> q<=d_sync, STABLE, cnt<=0.
//    At the same edge, rise<=d_sync or fall<=!d_sync.
//  rise/fall are registered and high for exactly one cycle, coincident with the first cycle of new q.
//   Otherwise they are 0.
//  Latency: d_async first sampled high at edge 1 and held -> q=1 and rise=1 after
//   edge SYNC_STAGES+STABLE_CYCLES (default: edge 6).
//  Level accepted iff d_sync differs from q for STABLE_CYCLES consecutive samples.
//  busy = (state==CHECK), combinational from the state register.
//  An opposite transition back-to-back with an accepted one re-enters CHECK on the next
//   mismatch sample; the minimum spacing between pulses is STABLE_CYCLES cycles.
// CONFIGURATION
//  Macro INPUT_DEBOUNCE_FALL_EDGE_EN.
//   Defined: fall pulse generated as described above.
//   Undefined: fall flop not instantiated; fall tied to 1'b0. q, rise and busy are unchanged.
//   The port list is identical in both builds.
// STRUCTURE
//  Package debounce_pkg holds:
//   typedef enum logic {STABLE, CHECK} db_state_e
//   localparam int DB_MIN_STABLE = 2 (shared legality check)
//  Sub-module sync_chain #(N, RESET_LEVEL): N-stage 1-bit synchroniser with sync reset.
//   Reused by other pin inputs in the codebase.
// TESTING (defaults SYNC=2, STABLE=4, RESET_LEVEL=0)
//  1. Reset hold, then d_async 0->1 and hold.
//     -> q=0 until edge 6; q=1 from edge 6. rise=1 for that single cycle; busy high for edges 3..5.
//  2. d_async high for 3 cycles, then 0 -> q stays 0, rise never asserts, busy drops after the glitch.
//  3. d_async high for exactly 4 cycles -> q goes 1 (rise pulse); later returns to 0 after 4 more cycles.
//  4. rst=1 for 1 cycle while busy=1 with cnt=3 -> next cycle q=0, busy=0, cnt=0, no rise/fall.
//     Qualification restarts from zero.
//  5. q=1, d_async 1->0 held, macro defined -> fall=1 one cycle at edge 6 of change.
//     Macro undefined -> fall stays 0 and q still goes 0.
//  6. Chatter: toggle d_async every cycle for 20 cycles -> q, rise and fall never change.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and limits for the pin debouncer and its synchroniser.
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } db_state_e;

    // Smallest legal value for both the synchroniser depth and the qualification length.
    localparam int DB_MIN_STABLE = 2;

endpackage

// File: rtl/sync_chain.sv
// N-stage single-bit synchroniser with synchronous reset to RESET_LEVEL.
// Shared by the pin inputs of the codebase; no logic sits between stages.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int   N           = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] s;

    if (N < DB_MIN_STABLE) begin : g_bad_n
        $error("sync_chain: N must be >= %0d", DB_MIN_STABLE);
    end

    // Shift the raw pin through the flop chain; reset loads every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s <= {N{RESET_LEVEL}};
        end else begin
            s <= {s[N-2:0], d};
        end
    end

    assign q = s[N-1];

endmodule

// File: rtl/input_debounce.sv
// Synchronise and debounce an asynchronous pin; emit a clean level plus
// registered one-cycle rise/fall pulses coincident with the first cycle of new q.
// Build option: INPUT_DEBOUNCE_FALL_EDGE_EN enables the fall pulse flop;
// without it fall is tied low and everything else is identical.
module input_debounce
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < DB_MIN_STABLE) begin : g_bad_stable
        $error("input_debounce: STABLE_CYCLES must be >= %0d", DB_MIN_STABLE);
    end

    db_state_e     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          d_sync;
    logic          mismatch;
    logic          accept;

    sync_chain #(
        .N           (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_async),
        .q   (d_sync)
    );

    assign mismatch = (d_sync != q);

    // State and qualification counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: count consecutive mismatches, accept on the last one, drop on any match.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            STABLE: begin
                if (mismatch) begin
                    state_n = CHECK;
                    cnt_n   = CW'(1);
                end
            end
            CHECK: begin
                if (!mismatch) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    accept  = 1'b1;
                    state_n = STABLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = STABLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Debounced level and rise pulse, updated on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RESET_LEVEL;
            rise <= 1'b0;
        end else begin
            if (accept) begin
                q <= d_sync;
            end
            rise <= accept & d_sync;
        end
    end

`ifdef INPUT_DEBOUNCE_FALL_EDGE_EN
    // Fall pulse, mirror of rise for a 1->0 acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            fall <= 1'b0;
        end else begin
            fall <= accept & ~d_sync;
        end
    end
`else
    assign fall = 1'b0;
`endif

    assign busy = (state == CHECK);

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce at default parameters (SYNC=2, STABLE=4, RESET_LEVEL=0).
// Edge numbers k count rising edges after d_async is first changed.
module tb_input_debounce;

`ifdef INPUT_DEBOUNCE_FALL_EDGE_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic d_async;
    logic q;
    logic rise;
    logic fall;
    logic busy;

    int checks;
    int errors;

    input_debounce #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .RESET_LEVEL   (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_async (d_async),
        .q       (q),
        .rise    (rise),
        .fall    (fall),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int k, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int k,
                             input logic eq, input logic er, input logic ef, input logic eb);
        check({tag, ".q"},    k, q,    eq);
        check({tag, ".rise"}, k, rise, er);
        check({tag, ".fall"}, k, fall, ef);
        check({tag, ".busy"}, k, busy, eb);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        d_async = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        check_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // 1: 0->1 held: q and rise at edge 6, busy on edges 3..5
        d_async = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_all("t1_rise", k, k >= 6, k == 6, 1'b0, k >= 3 && k <= 5);
        end

        // 5: q=1, 1->0 held: q falls at edge 6, fall pulse only in the macro build
        d_async = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_all("t5_fall", k, k < 6, 1'b0, FALL_EN && k == 6, k >= 3 && k <= 5);
        end

        // 2: 3-cycle glitch rejected
        d_async = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 3) d_async = 1'b0;
            check_all("t2_glitch", k, 1'b0, 1'b0, 1'b0, k >= 3 && k <= 5);
        end

        // 3: exactly 4 cycles high accepted, then back to 0 four cycles later
        d_async = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 4) d_async = 1'b0;
            check_all("t3_pulse4", k, k >= 6 && k <= 9, k == 6, FALL_EN && k == 10,
                      (k >= 3 && k <= 5) || (k >= 7 && k <= 9));
        end

        // 4: reset during qualification with cnt=3 discards it
        d_async = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        check("t4_pre.busy", 5, busy, 1'b1);
        check("t4_pre.cnt3", 5, dut.cnt == 3'd3, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all("t4_rst", 6, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_rst.cnt0", 6, dut.cnt == 3'd0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            step();
            check_all("t4_restart", k, k >= 6, k == 6, 1'b0, k >= 3 && k <= 5);
        end

        // Return to q=0 before chatter
        d_async = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        check("settle.q", 8, q, 1'b0);

        // 6: toggling every cycle never qualifies
        for (int k = 1; k <= 20; k++) begin
            d_async = ~d_async;
            step();
            check("t6_chatter.q",    k, q,    1'b0);
            check("t6_chatter.rise", k, rise, 1'b0);
            check("t6_chatter.fall", k, fall, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
